conv_win_engine: RTL and testbench

CONV_WIN_ENGINE -- requirements
Module: conv_win_engine

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_mac_tree.sv | 96 +++++++++
 rtl/conv_win_engine.sv | 198 +++++++++++++++++++
 tb/tb_conv_win_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window engine.
//   conv_state_e : sweep controller states
//   *_DEF        : default parameter values
//   idx_w()      : index width for n items (at least 1 bit)
//   acc_w()      : full-precision accumulator width for a K x K window
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } conv_state_e;

  localparam int PIX_W_DEF  = 8;
  localparam int COEF_W_DEF = 8;
  localparam int K_DEF      = 3;
  localparam int COLS_DEF   = 22;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One extra bit beyond pix*coef covers the unsigned-by-signed product,
  // and clog2(K*K) bits cover the growth of the K*K-term sum.
  function automatic int acc_w(input int pix_w, input int coef_w, input int k);
    return pix_w + coef_w + 1 + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Multiply and adder-tree stages of the window datapath.
//   clk, reset     : clock, async active-low reset
//   en             : advance both stages (low = hold everything)
//   in_valid/tag   : window issue qualifier and its column tag
//   pix_flat       : K*K unsigned pixels, tap k at [k*PIX_W +: PIX_W]
//   coef_flat      : K*K signed coefficients, tap k at [k*COEF_W +: COEF_W]
//   out_valid/tag  : stage-2 qualifier and column tag
//   out_sum        : full-precision signed window sum
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int K      = K_DEF,
  parameter int ACC_W  = acc_w(PIX_W_DEF, COEF_W_DEF, K_DEF),
  parameter int TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [K*K*PIX_W-1:0]      pix_flat,
  input  logic [K*K*COEF_W-1:0]     coef_flat,
  output logic                      out_valid,
  output logic [TAG_W-1:0]          out_tag,
  output logic signed [ACC_W-1:0]   out_sum
);

  localparam int NTAP   = K * K;
  localparam int PROD_W = PIX_W + COEF_W + 1;

  logic signed [PROD_W-1:0] prod_q [NTAP];
  logic signed [PROD_W-1:0] prod_d [NTAP];
  logic                     v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]         t1_q, t1_d, t2_q, t2_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d, tree_sum;

  // Pixels are zero-extended and coefficients sign-extended to the product
  // width so the multiply is a plain signed multiply with no overflow.
  always_comb begin
    v1_d = v1_q;
    t1_d = t1_q;
    for (int k = 0; k < NTAP; k++) prod_d[k] = prod_q[k];
    if (en) begin
      v1_d = in_valid;
      t1_d = in_tag;
      for (int k = 0; k < NTAP; k++) begin
        prod_d[k] = $signed({{(PROD_W-PIX_W){1'b0}}, pix_flat[k*PIX_W +: PIX_W]}) *
                    $signed({{(PROD_W-COEF_W){coef_flat[k*COEF_W+COEF_W-1]}},
                             coef_flat[k*COEF_W +: COEF_W]});
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < NTAP; k++) begin
      tree_sum = tree_sum + $signed({{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]});
    end
  end

  always_comb begin
    v2_d  = v2_q;
    t2_d  = t2_q;
    sum_d = sum_q;
    if (en) begin
      v2_d  = v1_q;
      t2_d  = t1_q;
      sum_d = tree_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAP; k++) prod_q[k] <= '0;
      v1_q  <= 1'b0;
      t1_q  <= '0;
      v2_q  <= 1'b0;
      t2_q  <= '0;
      sum_q <= '0;
    end else begin
      for (int k = 0; k < NTAP; k++) prod_q[k] <= prod_d[k];
      v1_q  <= v1_d;
      t1_q  <= t1_d;
      v2_q  <= v2_d;
      t2_q  <= t2_d;
      sum_q <= sum_d;
    end
  end

  assign out_valid = v2_q;
  assign out_tag   = t2_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/conv_win_engine.sv
// K x K sliding-window convolution engine over a K-row image buffer.
//   clk, reset           : clock, async active-low reset
//   row_valid/row_ready  : load one row into the buffer (IDLE only)
//   row_data             : COLS pixels, pixel c at [c*PIX_W +: PIX_W]
//   coef_we/idx/data     : coefficient write (IDLE only, idx < K*K)
//   start                : request one column sweep (needs K rows loaded)
//   out_valid/out_ready  : result handshake
//   out_data, out_col    : window sum and its leftmost column
//   busy, done           : sweep in progress, sweep-complete pulse
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | accept rows, coefficient writes and start
// ST_SWEEP | issue one window per unstalled cycle, columns ascending
// ST_DRAIN | all windows issued; wait for the last result to leave
module conv_win_engine
  import conv_pkg::*;
#(
  parameter  int PIX_W  = PIX_W_DEF,
  parameter  int COEF_W = COEF_W_DEF,
  parameter  int K      = K_DEF,
  parameter  int COLS   = COLS_DEF,
  localparam int ACC_W  = acc_w(PIX_W, COEF_W, K),
  localparam int CIDX_W = idx_w(K * K),
  localparam int COL_W  = idx_w(COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [COLS*PIX_W-1:0]    row_data,
  input  logic                     coef_we,
  input  logic [CIDX_W-1:0]        coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [COL_W-1:0]         out_col,
  output logic                     busy,
  output logic                     done
);

  localparam int                 NTAP       = K * K;
  localparam int                 CNT_W      = idx_w(K + 1);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(K);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - K);

  conv_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [COLS*PIX_W-1:0]     rows_q [K];
  logic [COLS*PIX_W-1:0]     rows_d [K];
  logic signed [COEF_W-1:0]  coef_q [NTAP];
  logic signed [COEF_W-1:0]  coef_d [NTAP];
  logic [COL_W-1:0]          col_q, col_d;
  logic                      rdy_en_q, rdy_en_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  logic [COL_W-1:0]          out_col_q, out_col_d;

  logic                      row_acc, start_acc, stall, last_acc, issue_valid, done_o;
  logic [NTAP*PIX_W-1:0]     win_pix;
  logic [NTAP*COEF_W-1:0]    win_coef;
  logic                      mac_valid;
  logic [COL_W-1:0]          mac_tag;
  logic signed [ACC_W-1:0]   mac_sum;

  // rdy_en_q keeps row_ready low during reset and releases it one clock later.
  assign row_ready   = rdy_en_q && (state_q == ST_IDLE);
  assign row_acc     = row_valid && row_ready;
  assign start_acc   = start && (state_q == ST_IDLE) && (cnt_q == FULL_CNT);
  // A single global stall freezes issue and every pipeline stage together,
  // so ordering is preserved without any skid buffering.
  assign stall       = out_valid_q && !out_ready;
  assign last_acc    = out_valid_q && out_ready && (out_col_q == LAST_COL);
  assign issue_valid = (state_q == ST_SWEEP) && !stall;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_SWEEP;
          col_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (issue_valid) begin
          if (col_q == LAST_COL) state_d = ST_DRAIN;
          else                   col_d   = col_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_acc) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Row buffer: new row lands in slot K-1, slot 0 falls off.
  always_comb begin
    rdy_en_d = 1'b1;
    cnt_d    = cnt_q;
    for (int i = 0; i < K; i++) rows_d[i] = rows_q[i];
    if (row_acc) begin
      for (int i = 0; i < K - 1; i++) rows_d[i] = rows_q[i + 1];
      rows_d[K-1] = row_data;
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < NTAP; k++) coef_d[k] = coef_q[k];
    if (coef_we && (state_q == ST_IDLE) && (int'(coef_idx) < NTAP)) begin
      coef_d[coef_idx] = coef_data;
    end
  end

  always_comb begin
    win_pix  = '0;
    win_coef = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_pix[(i*K + j)*PIX_W +: PIX_W] = rows_q[i][(int'(col_q) + j)*PIX_W +: PIX_W];
      end
    end
    for (int k = 0; k < NTAP; k++) win_coef[k*COEF_W +: COEF_W] = coef_q[k];
  end

  conv_mac_tree #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .K      (K),
    .ACC_W  (ACC_W),
    .TAG_W  (COL_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .en        (!stall),
    .in_valid  (issue_valid),
    .in_tag    (col_q),
    .pix_flat  (win_pix),
    .coef_flat (win_coef),
    .out_valid (mac_valid),
    .out_tag   (mac_tag),
    .out_sum   (mac_sum)
  );

  // Output register keeps its last value when no new result arrives.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    if (!stall) begin
      out_valid_d = mac_valid;
      if (mac_valid) begin
        out_data_d = mac_sum;
        out_col_d  = mac_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < K; i++)    rows_q[i] <= '0;
      for (int k = 0; k < NTAP; k++) coef_q[k] <= '0;
      col_q       <= '0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < K; i++)    rows_q[i] <= rows_d[i];
      for (int k = 0; k < NTAP; k++) coef_q[k] <= coef_d[k];
      col_q       <= col_d;
      rdy_en_q    <= rdy_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_o;

endmodule

// File: tb/tb_conv_win_engine.sv
// Scoreboard bench for conv_win_engine: the stimulus side keeps an
// arithmetic image/coefficient model and queues expected results per sweep;
// a monitor pops and compares every accepted result.
module tb_conv_win_engine;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int K      = 3;
  localparam int COLS   = 22;
  localparam int ACC_W  = 21;
  localparam int NTAP   = K * K;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     row_valid = 1'b0;
  logic                     row_ready;
  logic [COLS*PIX_W-1:0]    row_data = '0;
  logic                     coef_we = 1'b0;
  logic [3:0]               coef_idx = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     start = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [ACC_W-1:0]  out_data;
  logic [4:0]               out_col;
  logic                     busy;
  logic                     done;

  always #5 clk = ~clk;

  conv_win_engine #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .K      (K),
    .COLS   (COLS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .coef_we   (coef_we),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .start     (start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int col;
    int val;
  } exp_t;

  int   m_pix [K][COLS];
  int   m_coef [NTAP];
  int   m_cnt;
  bit   m_idle;
  exp_t sb [$];
  int   row_buf [COLS];

  int   done_cnt = 0;
  int   stall7_cnt = 0;
  int   bp_mode = 0;
  bit   bp_hit = 0;

  function automatic void model_clear();
    for (int i = 0; i < K; i++)
      for (int c = 0; c < COLS; c++) m_pix[i][c] = 0;
    for (int k = 0; k < NTAP; k++) m_coef[k] = 0;
    m_cnt  = 0;
    m_idle = 1'b1;
  endfunction

  function automatic void model_shift();
    for (int i = 0; i < K - 1; i++)
      for (int c = 0; c < COLS; c++) m_pix[i][c] = m_pix[i+1][c];
    for (int c = 0; c < COLS; c++) m_pix[K-1][c] = row_buf[c];
    if (m_cnt < K) m_cnt++;
  endfunction

  function automatic void model_sweep();
    for (int c = 0; c <= COLS - K; c++) begin
      int s;
      s = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) s += m_pix[i][c+j] * m_coef[i*K + j];
      sb.push_back('{col: c, val: s});
    end
  endfunction

  function automatic logic [COLS*PIX_W-1:0] pack_row();
    logic [COLS*PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*PIX_W +: PIX_W] = PIX_W'(row_buf[c]);
    return r;
  endfunction

  function automatic void rand_row();
    for (int c = 0; c < COLS; c++) row_buf[c] = int'($urandom_range(0, 255));
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    logic prev_st;
    int   prev_data;
    int   prev_col;
    prev_st = 1'b0;
    prev_data = 0;
    prev_col = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_st = 1'b0;
      end else begin
        if (prev_st) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", $signed(out_data), prev_data);
          check("hold_col", out_col, prev_col);
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_col", out_col, e.col);
            check("out_data", $signed(out_data), e.val);
          end
        end
        prev_st   = out_valid && !out_ready;
        prev_data = int'(out_data);
        prev_col  = int'(out_col);
        if (prev_st && out_col == 5'd7) stall7_cnt++;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (bp_mode == 2 && out_valid && out_col == 5'd7 && !bp_hit) begin
        bp_hit = 1'b1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic put_row();
    row_data  = pack_row();
    row_valid = 1'b1;
    check("row_ready_idle", row_ready, m_idle);
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    if (m_idle) model_shift();
  endtask

  task automatic write_coef(input int idx, input int val);
    coef_we   = 1'b1;
    coef_idx  = idx[3:0];
    coef_data = val[7:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (m_idle && idx < NTAP) m_coef[idx] = coef_data;
  endtask

  task automatic start_sweep(input bit with_row);
    bit acc;
    acc = m_idle && (m_cnt == K);
    start = 1'b1;
    if (with_row) begin
      row_data  = pack_row();
      row_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    row_valid = 1'b0;
    if (with_row && m_idle) model_shift();
    if (acc) begin
      model_sweep();
      m_idle = 1'b0;
    end
    check("busy_after_start", busy, acc);
  endtask

  task automatic wait_sweep(input bit poke);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (busy && n < 2000) begin
      if (poke && n == 2) begin
        for (int c = 0; c < COLS; c++) row_data[c*PIX_W +: PIX_W] = PIX_W'($urandom);
        row_valid = 1'b1;
        coef_we   = 1'b1;
        coef_idx  = 4'd0;
        coef_data = 8'sd55;
        check("row_ready_in_sweep", row_ready, 0);
      end else begin
        row_valid = 1'b0;
        coef_we   = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    row_valid = 1'b0;
    coef_we   = 1'b0;
    check("sweep_finished", n < 2000, 1);
    check("results_left", sb.size(), 0);
    check("done_pulses", done_cnt - d0, 1);
    m_idle = 1'b1;
  endtask

  task automatic rand_coefs();
    for (int k = 0; k < NTAP; k++) write_coef(k, int'($urandom_range(0, 255)));
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int n;
    int seen;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_col", out_col, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row_ready", row_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("row_ready_after_rst", row_ready, 1);
    check("busy_idle", busy, 0);

    // identity kernel: centre tap only
    write_coef(4, 1);
    write_coef(12, 99);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < COLS; c++) row_buf[c] = 16 * r + c;
      put_row();
    end
    start_sweep(1'b0);
    wait_sweep(1'b0);

    // all-ones kernel on saturated pixels
    for (int k = 0; k < NTAP; k++) write_coef(k, 1);
    for (int c = 0; c < COLS; c++) row_buf[c] = 255;
    repeat (K) put_row();
    start_sweep(1'b0);
    wait_sweep(1'b0);

    // most-negative kernel on saturated pixels
    for (int k = 0; k < NTAP; k++) write_coef(k, -128);
    start_sweep(1'b0);
    wait_sweep(1'b0);

    // directed backpressure at column 7, plus pokes during the sweep
    rand_coefs();
    repeat (K) begin
      rand_row();
      put_row();
    end
    bp_mode = 2;
    bp_hit = 1'b0;
    stall7_cnt = 0;
    start_sweep(1'b0);
    wait_sweep(1'b1);
    check("stall_cycles_col7", stall7_cnt, 5);
    bp_mode = 0;

    // random sweeps with random backpressure and row+start together
    bp_mode = 1;
    repeat (4) begin
      rand_coefs();
      write_coef(int'($urandom_range(9, 15)), int'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 2)) begin
        rand_row();
        put_row();
      end
      rand_row();
      start_sweep(bit'($urandom_range(0, 1)));
      wait_sweep(bit'($urandom_range(0, 1)));
    end
    bp_mode = 0;
    @(posedge clk);
    #1;

    // reset in the middle of a sweep
    rand_coefs();
    start_sweep(1'b0);
    n = 0;
    while (!(out_valid && out_col == 5'd5) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_col5", n < 200, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", $signed(out_data), 0);
    check("mid_rst_out_col", out_col, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_row_ready", row_ready, 0);
    sb.delete();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("row_ready_after_mid_rst", row_ready, 1);

    // start ignored with zero rows, then with two rows
    start_sweep(1'b0);
    rand_coefs();
    repeat (2) begin
      rand_row();
      put_row();
    end
    start_sweep(1'b0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    check("guard_no_activity", seen, 0);
    rand_row();
    put_row();
    start_sweep(1'b0);
    wait_sweep(1'b0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
